// File: rtl/mux8_scan_seq_if.sv
// rtl/mux8_scan_seq_if.sv - load handshake and mux drive bundle for mux8_scan_seq
interface mux8_scan_seq_if;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [7:0] mux_in;
   logic [2:0] mux_sel;
   logic       bit_valid;
   logic       bit_first;
   logic       bit_last;
   logic       busy;
   logic       done;

   modport slave (
      input  load_valid, load_data,
      output load_ready, mux_in, mux_sel, bit_valid, bit_first, bit_last, busy, done
   );

   modport master (
      output load_valid, load_data,
      input  load_ready, mux_in, mux_sel, bit_valid, bit_first, bit_last, busy, done
   );
endinterface

// File: rtl/mux8_scan_seq.sv
// rtl/mux8_scan_seq.sv - captures a word and steps an 8:1 mux select with sample strobes
module mux8_scan_seq #(
   parameter int HOLD_CYCLES = 1,
   parameter bit MSB_FIRST   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   mux8_scan_seq_if.slave s
);
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] SEL_END   = MSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] data_q, data_d;
   logic       done_q, done_d;
   logic       tick_w;

   // Sample point: last cycle of the hold window for the current select.
   assign tick_w = (state_q == SCAN) && (cnt_q == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         sel_q   <= SEL_START;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (s.load_valid) begin
               data_d  = s.load_data;
               sel_d   = SEL_START;
               cnt_d   = 8'd0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (tick_w) begin
               cnt_d = 8'd0;
               if (sel_q == SEL_END) begin
                  state_d = IDLE;
                  sel_d   = SEL_START;
                  done_d  = 1'b1;
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - 3'd1;
               end else begin
                  sel_d = sel_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s.load_ready = (state_q == IDLE);
      s.busy       = (state_q == SCAN);
      s.mux_in     = data_q;
      s.mux_sel    = sel_q;
      s.bit_valid  = tick_w;
      s.bit_first  = tick_w && (sel_q == SEL_START);
      s.bit_last   = tick_w && (sel_q == SEL_END);
      s.done       = done_q;
   end
endmodule
